// File: rtl/pt_decoder_pkg.sv
// Pseudoternary line-code constants and polarity FSM states.
// Shared by the decoder and its Coder partner.
package pt_pkg;

    localparam logic [1:0] PT_ZERO = 2'b00;
    localparam logic [1:0] PT_POS  = 2'b01;
    localparam logic [1:0] PT_NEG  = 2'b11;
    localparam logic [1:0] PT_ILL  = 2'b10;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        EXP_POS = 2'd1,
        EXP_NEG = 2'd2
    } pol_state_t;

endpackage

// File: rtl/pt_decoder_if.sv
// Symbol-in / bit-and-word-out bundle of the pseudoternary decoder.
// The slave side is the decoder; the master side feeds symbols.
interface pt_decoder_if #(
    parameter int N     = 23,
    parameter int ERR_W = 8
);
    logic [1:0]       code_i;
    logic             sym_valid_i;
    logic             clr_i;
    logic             bit_o;
    logic             bit_valid_o;
    logic [N-1:0]     word_o;
    logic             word_valid_o;
    logic             word_err_o;
    logic             viol_o;
    logic             illegal_o;
    logic [ERR_W-1:0] err_cnt_o;

    modport master (
        output code_i, sym_valid_i, clr_i,
        input  bit_o, bit_valid_o, word_o, word_valid_o,
        input  word_err_o, viol_o, illegal_o, err_cnt_o
    );

    modport slave (
        input  code_i, sym_valid_i, clr_i,
        output bit_o, bit_valid_o, word_o, word_valid_o,
        output word_err_o, viol_o, illegal_o, err_cnt_o
    );
endinterface

// File: rtl/pt_deser.sv
// LSB-first deserialiser: shifts decoded bits into N-bit words
// and flags words that carried any line error.
module pt_deser #(
    parameter int N = 23
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         clr_i,
    input  logic         acc_i,
    input  logic         bit_i,
    input  logic         err_i,
    output logic [N-1:0] word_o,
    output logic         word_valid_o,
    output logic         word_err_o
);
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    logic [CW-1:0] cnt_q, cnt_eff;
    logic [N-1:0]  sh_q, sh_eff, sh_nxt;
    logic          st_q, st_eff, last;

    // Clear takes effect before a same-edge symbol is stored
    always_comb begin
        cnt_eff = clr_i ? '0 : cnt_q;
        sh_eff  = clr_i ? '0 : sh_q;
        st_eff  = clr_i ? 1'b0 : st_q;
        sh_nxt  = sh_eff | (N'(bit_i) << cnt_eff);
        last    = (cnt_eff == CW'(N - 1));
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            cnt_q        <= '0;
            sh_q         <= '0;
            st_q         <= 1'b0;
            word_o       <= '0;
            word_valid_o <= 1'b0;
            word_err_o   <= 1'b0;
        end else begin
            word_valid_o <= 1'b0;
            word_err_o   <= 1'b0;
            cnt_q        <= cnt_eff;
            sh_q         <= sh_eff;
            st_q         <= st_eff;
            if (acc_i) begin
                if (last) begin
                    word_o       <= sh_nxt;
                    word_valid_o <= 1'b1;
                    word_err_o   <= st_eff | err_i;
                    cnt_q        <= '0;
                    sh_q         <= '0;
                    st_q         <= 1'b0;
                end else begin
                    sh_q  <= sh_nxt;
                    cnt_q <= cnt_eff + 1'b1;
                    st_q  <= st_eff | err_i;
                end
            end
        end
    end
endmodule

// File: rtl/pt_decoder.sv
// Pseudoternary decoder: symbol decode, mark-polarity check,
// saturating error count, word assembly via pt_deser.
module pt_decoder
    import pt_pkg::*;
#(
    parameter int N     = 23,
    parameter int ERR_W = 8
) (
    input logic         clk_i,
    input logic         rst_i,
    pt_decoder_if.slave bus
);
    pol_state_t state_q, state_d, cur;

    logic is_zero, is_pos, is_neg, is_ill;
    logic dec_bit, dec_viol, dec_ill, acc;

    logic             bit_q, bval_q, viol_q, ill_q;
    logic [ERR_W-1:0] cnt_q;

    assign acc     = bus.sym_valid_i;
    assign is_zero = (bus.code_i == PT_ZERO);
    assign is_pos  = (bus.code_i == PT_POS);
    assign is_neg  = (bus.code_i == PT_NEG);
    assign is_ill  = (bus.code_i == PT_ILL);
    assign cur     = bus.clr_i ? IDLE : state_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // A mark always resyncs expectation to the opposite polarity
    always_comb begin
        state_d = cur;
        if (acc && is_pos) state_d = EXP_NEG;
        if (acc && is_neg) state_d = EXP_POS;
    end

    always_comb begin
        dec_bit  = 1'b0;
        dec_viol = 1'b0;
        dec_ill  = 1'b0;
        unique case (1'b1)
            is_zero: dec_bit  = 1'b1;
            is_ill:  dec_ill  = 1'b1;
            is_pos:  dec_viol = (cur == EXP_NEG);
            is_neg:  dec_viol = (cur == EXP_POS);
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bit_q  <= 1'b0;
            bval_q <= 1'b0;
            viol_q <= 1'b0;
            ill_q  <= 1'b0;
            cnt_q  <= '0;
        end else begin
            bval_q <= acc;
            viol_q <= acc & dec_viol;
            ill_q  <= acc & dec_ill;
            if (acc) bit_q <= dec_bit;
            if (acc && (dec_viol || dec_ill) && cnt_q != '1)
                cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bus.bit_o       = bit_q;
    assign bus.bit_valid_o = bval_q;
    assign bus.viol_o      = viol_q;
    assign bus.illegal_o   = ill_q;
    assign bus.err_cnt_o   = cnt_q;

    logic [N-1:0] word;
    logic         wval, werr;

    pt_deser #(.N(N)) u_deser (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .clr_i       (bus.clr_i),
        .acc_i       (acc),
        .bit_i       (dec_bit),
        .err_i       (dec_viol | dec_ill),
        .word_o      (word),
        .word_valid_o(wval),
        .word_err_o  (werr)
    );

    assign bus.word_o       = word;
    assign bus.word_valid_o = wval;
    assign bus.word_err_o   = werr;
endmodule

// File: tb/tb_pt_decoder.sv
// Scoreboard bench for pt_decoder: directed symbol streams,
// expected bits/words queued at issue and popped by a monitor.
module tb_pt_decoder;
    import pt_pkg::*;

    localparam int N     = 23;
    localparam int ERR_W = 8;

    logic CLK_tb;
    logic rst;

    typedef struct {
        logic b;
        logic v;
        logic i;
    } bexp_t;

    typedef struct {
        logic [N-1:0] w;
        logic         e;
    } wexp_t;

    bexp_t bq[$];
    wexp_t wq[$];

    int checks;
    int errs;

    pt_decoder_if #(.N(N), .ERR_W(ERR_W)) bus ();

    pt_decoder #(.N(N), .ERR_W(ERR_W)) dut (
        .clk_i(CLK_tb),
        .rst_i(rst),
        .bus  (bus.slave)
    );

    initial CLK_tb = 1'b0;
    always #5 CLK_tb = ~CLK_tb;

    task automatic chk(input string nm,
                       input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errs++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    always @(negedge CLK_tb) begin
        bexp_t be;
        wexp_t we;
        if (bus.bit_valid_o) begin
            if (bq.size() == 0) begin
                chk("spurious_bit", 1, 0);
            end else begin
                be = bq.pop_front();
                chk("bit_viol_ill",
                    {bus.bit_o, bus.viol_o, bus.illegal_o},
                    {be.b, be.v, be.i});
            end
        end else if (bus.viol_o || bus.illegal_o) begin
            chk("strobe_no_bit", 1, 0);
        end
        if (bus.word_valid_o) begin
            if (wq.size() == 0) begin
                chk("spurious_word", 1, 0);
            end else begin
                we = wq.pop_front();
                chk("word_err",
                    {bus.word_o, bus.word_err_o},
                    {we.w, we.e});
            end
        end else if (bus.word_err_o) begin
            chk("werr_no_valid", 1, 0);
        end
    end

    task automatic step();
        @(posedge CLK_tb);
        #1;
    endtask

    task automatic send(input logic [1:0] c,
                        input logic b,
                        input logic v,
                        input logic il,
                        input logic cl);
        bexp_t e;
        e.b = b;
        e.v = v;
        e.i = il;
        bq.push_back(e);
        bus.code_i      = c;
        bus.sym_valid_i = 1'b1;
        bus.clr_i       = cl;
        step();
        bus.sym_valid_i = 1'b0;
        bus.clr_i       = 1'b0;
    endtask

    task automatic push_word(input logic [N-1:0] w,
                             input logic e);
        wexp_t x;
        x.w = w;
        x.e = e;
        wq.push_back(x);
    endtask

    task automatic clear();
        bus.clr_i = 1'b1;
        step();
        bus.clr_i = 1'b0;
    endtask

    // Coder behaviour: 1 -> zero, 0 -> alternating marks
    task automatic send_word(input logic [N-1:0] w);
        logic pol;
        pol = 1'b0;
        push_word(w, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (w[i]) begin
                send(PT_ZERO, 1, 0, 0, 0);
            end else begin
                send(pol ? PT_NEG : PT_POS, 0, 0, 0, 0);
                pol = ~pol;
            end
        end
    endtask

    task automatic check_reset_state(input string nm);
        chk({nm, "_strobes"},
            {bus.bit_o, bus.bit_valid_o, bus.word_valid_o,
             bus.word_err_o, bus.viol_o, bus.illegal_o}, 0);
        chk({nm, "_word"}, bus.word_o, 0);
        chk({nm, "_errcnt"}, bus.err_cnt_o, 0);
    endtask

    initial begin
        checks = 0;
        errs   = 0;
        rst             = 1'b1;
        bus.code_i      = PT_ZERO;
        bus.sym_valid_i = 1'b0;
        bus.clr_i       = 1'b0;
        step();
        step();
        rst = 1'b0;
        @(negedge CLK_tb);
        check_reset_state("reset");
        step();

        // 1: clean Coder word
        send_word(23'd8201481);
        step();
        step();
        chk("t1_errcnt", bus.err_cnt_o, 0);
        chk("t1_bit_hold", {bus.bit_o, bus.bit_valid_o}, 2'b10);

        // 2: +,0,+ violates, then - is fine
        clear();
        push_word(23'h7FFFF2, 1'b1);
        send(PT_POS, 0, 0, 0, 0);
        send(PT_ZERO, 1, 0, 0, 0);
        send(PT_POS, 0, 1, 0, 0);
        send(PT_NEG, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) send(PT_ZERO, 1, 0, 0, 0);
        step();
        chk("t2_errcnt", bus.err_cnt_o, 1);

        // 3: illegal keeps the pre-illegal polarity
        clear();
        push_word(23'h7FFFF0, 1'b1);
        send(PT_POS, 0, 0, 0, 0);
        send(PT_ILL, 0, 0, 1, 0);
        send(PT_POS, 0, 1, 0, 0);
        send(PT_NEG, 0, 0, 0, 0);
        for (int i = 0; i < 19; i++) send(PT_ZERO, 1, 0, 0, 0);
        step();
        chk("t3_errcnt", bus.err_cnt_o, 3);

        // 4: clear with 11th symbol realigns the word
        clear();
        for (int i = 0; i < 10; i++)
            send((i % 2) ? PT_NEG : PT_POS, 0, 0, 0, 0);
        push_word(23'h7FFFFE, 1'b0);
        send(PT_NEG, 0, 0, 0, 1);
        for (int i = 0; i < 22; i++) send(PT_ZERO, 1, 0, 0, 0);
        step();
        chk("t4_errcnt", bus.err_cnt_o, 3);

        // 5: reset mid-word, then a clean word
        send(PT_POS, 0, 0, 0, 0);
        send(PT_ZERO, 1, 0, 0, 0);
        send(PT_NEG, 0, 0, 0, 0);
        send(PT_ZERO, 1, 0, 0, 0);
        send(PT_POS, 0, 0, 0, 0);
        rst             = 1'b1;
        bus.sym_valid_i = 1'b1;
        bus.code_i      = PT_POS;
        step();
        rst             = 1'b0;
        bus.sym_valid_i = 1'b0;
        @(negedge CLK_tb);
        check_reset_state("midrst");
        step();
        send_word(23'h2A5A5A);
        step();
        chk("t5_errcnt", bus.err_cnt_o, 0);

        // 6: 300 +marks with gaps, counter saturates
        clear();
        for (int i = 0; i < 300; i++) begin
            if (i % N == N - 1) push_word('0, 1'b1);
            send(PT_POS, 0, (i != 0), 0, 0);
            if (i % 3 == 2) step();
        end
        step();
        step();
        chk("t6_errcnt_sat", bus.err_cnt_o, 255);

        for (int k = 0; k < 50; k++) begin
            if (bq.size() == 0 && wq.size() == 0) break;
            step();
        end
        chk("bits_drained", bq.size(), 0);
        chk("words_drained", wq.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures",
                 checks, errs);
        $finish;
    end
endmodule
